// File: rtl/riscv_ctrl_pkg.sv
// Shared opcode ranges, op classes and MDU tracking states for the issue stage.
package riscv_ctrl_pkg;

    localparam logic [5:0] ALU_NOP   = 6'd0;
    localparam logic [5:0] ALU_FIRST = 6'd1;
    localparam logic [5:0] ALU_LAST  = 6'd30;
    localparam logic [5:0] MD_FIRST  = 6'd31;
    localparam logic [5:0] MD_LAST   = 6'd43;

    typedef enum logic [1:0] {
        CLS_NOP,
        CLS_ALU,
        CLS_MD
    } op_class_t;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_RUN,
        MD_WB
    } md_state_t;

    // Unassigned codes above MD_LAST fall through to NOP.
    function automatic op_class_t classify_op(input logic [5:0] code);
        op_class_t cls;
        cls = CLS_NOP;
        if (code == ALU_NOP) begin
            cls = CLS_NOP;
        end else if (code >= ALU_FIRST && code <= ALU_LAST) begin
            cls = CLS_ALU;
        end else if (code >= MD_FIRST && code <= MD_LAST) begin
            cls = CLS_MD;
        end
        return cls;
    endfunction

endpackage

// File: rtl/issue_hazard_chk.sv
// Combinational op classification and RAW/WAW check against the in-flight MDU destination.
module issue_hazard_chk
    import riscv_ctrl_pkg::*;
(
    input  logic [5:0] alu_control,
    input  logic [4:0] address_a,
    input  logic [4:0] address_b,
    input  logic [4:0] address_c,
    input  logic       muxb_control,
    input  logic       md_tag_valid,
    input  logic [4:0] md_rd,
    output op_class_t  op_class,
    output logic       hazard
);

    always_comb begin
        op_class = classify_op(alu_control);
        hazard   = 1'b0;
        // x0 is never written, so it can never carry a dependency.
        if (md_tag_valid && md_rd != 5'd0) begin
            hazard = (address_a == md_rd)
                  || (!muxb_control && address_b == md_rd)
                  || (address_c == md_rd);
        end
    end

endmodule

// File: rtl/alu_issue_sched.sv
// Issue controller: accepts decoded ops, launches ALU/MDU work, and shares the single write port.
module alu_issue_sched
    import riscv_ctrl_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int STARVE_MAX     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      halt,
    input  logic                      dec_valid,
    output logic                      dec_ready,
    input  logic [5:0]                dec_alu_control,
    input  logic [4:0]                dec_addressA,
    input  logic [4:0]                dec_addressB,
    input  logic [4:0]                dec_addressC,
    input  logic [BUS_DATA_WIDTH-1:0] dec_imm,
    input  logic                      dec_muxB_control,
    output logic                      iss_alu_valid,
    output logic                      iss_md_start,
    output logic [5:0]                iss_alu_control,
    output logic [4:0]                iss_addressA,
    output logic [4:0]                iss_addressB,
    output logic [4:0]                iss_addressC,
    output logic [BUS_DATA_WIDTH-1:0] iss_imm,
    output logic                      iss_muxB_control,
    input  logic                      md_ready,
    input  logic                      md_done,
    output logic                      md_ack,
    output logic                      wb_en,
    output logic                      wb_sel,
    output logic [4:0]                wb_addr,
    output logic                      busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIMIT = CNT_W'(STARVE_MAX);

    md_state_t                 state_q, state_d;
    logic                      md_tag_valid_q, md_tag_valid_d;
    logic [4:0]                md_rd_q, md_rd_d;
    logic [CNT_W-1:0]          starve_cnt_q, starve_cnt_d;
    logic                      iss_alu_valid_q, iss_alu_valid_d;
    logic                      iss_md_start_q, iss_md_start_d;
    logic [5:0]                iss_alu_control_q, iss_alu_control_d;
    logic [4:0]                iss_addressA_q, iss_addressA_d;
    logic [4:0]                iss_addressB_q, iss_addressB_d;
    logic [4:0]                iss_addressC_q, iss_addressC_d;
    logic [BUS_DATA_WIDTH-1:0] iss_imm_q, iss_imm_d;
    logic                      iss_muxB_control_q, iss_muxB_control_d;

    op_class_t op_class;
    logic      hazard;
    logic      starve_block;
    logic      accept;
    logic      md_ack_int;

    issue_hazard_chk u_hazard_chk (
        .alu_control  (dec_alu_control),
        .address_a    (dec_addressA),
        .address_b    (dec_addressB),
        .address_c    (dec_addressC),
        .muxb_control (dec_muxB_control),
        .md_tag_valid (md_tag_valid_q),
        .md_rd        (md_rd_q),
        .op_class     (op_class),
        .hazard       (hazard)
    );

    // dec_ready is gated by rst_n so every output reads 0 while reset is held.
    assign starve_block = (starve_cnt_q >= STARVE_LIMIT);
    assign dec_ready    = rst_n && !halt && !hazard && !starve_block
                       && (op_class != CLS_MD || (state_q == MD_IDLE && md_ready));
    assign accept       = dec_valid && dec_ready;
    assign md_ack_int   = md_done && (state_q != MD_IDLE) && !iss_alu_valid_q;

    always_comb begin
        state_d            = state_q;
        md_tag_valid_d     = md_tag_valid_q;
        md_rd_d            = md_rd_q;
        starve_cnt_d       = starve_cnt_q;
        iss_alu_valid_d    = 1'b0;
        iss_md_start_d     = 1'b0;
        iss_alu_control_d  = iss_alu_control_q;
        iss_addressA_d     = iss_addressA_q;
        iss_addressB_d     = iss_addressB_q;
        iss_addressC_d     = iss_addressC_q;
        iss_imm_d          = iss_imm_q;
        iss_muxB_control_d = iss_muxB_control_q;

        if (accept && op_class != CLS_NOP) begin
            iss_alu_valid_d    = (op_class == CLS_ALU);
            iss_md_start_d     = (op_class == CLS_MD);
            iss_alu_control_d  = dec_alu_control;
            iss_addressA_d     = dec_addressA;
            iss_addressB_d     = dec_addressB;
            iss_addressC_d     = dec_addressC;
            iss_imm_d          = dec_imm;
            iss_muxB_control_d = dec_muxB_control;
        end

        unique case (state_q)
            MD_IDLE: begin
                if (accept && op_class == CLS_MD) begin
                    state_d        = MD_RUN;
                    md_tag_valid_d = 1'b1;
                    md_rd_d        = dec_addressC;
                end
            end
            MD_RUN: begin
                if (md_ack_int) begin
                    state_d        = MD_IDLE;
                    md_tag_valid_d = 1'b0;
                end else if (md_done) begin
                    state_d = MD_WB;
                end
            end
            MD_WB: begin
                if (md_ack_int) begin
                    state_d        = MD_IDLE;
                    md_tag_valid_d = 1'b0;
                end
            end
            default: begin
                state_d        = MD_IDLE;
                md_tag_valid_d = 1'b0;
            end
        endcase

        // A refused MDU result eventually blocks new issue so the ALU stream frees the port.
        if (md_ack_int) begin
            starve_cnt_d = '0;
        end else if (md_done && !starve_block) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q            <= MD_IDLE;
            md_tag_valid_q     <= 1'b0;
            md_rd_q            <= '0;
            starve_cnt_q       <= '0;
            iss_alu_valid_q    <= 1'b0;
            iss_md_start_q     <= 1'b0;
            iss_alu_control_q  <= '0;
            iss_addressA_q     <= '0;
            iss_addressB_q     <= '0;
            iss_addressC_q     <= '0;
            iss_imm_q          <= '0;
            iss_muxB_control_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            md_tag_valid_q     <= md_tag_valid_d;
            md_rd_q            <= md_rd_d;
            starve_cnt_q       <= starve_cnt_d;
            iss_alu_valid_q    <= iss_alu_valid_d;
            iss_md_start_q     <= iss_md_start_d;
            iss_alu_control_q  <= iss_alu_control_d;
            iss_addressA_q     <= iss_addressA_d;
            iss_addressB_q     <= iss_addressB_d;
            iss_addressC_q     <= iss_addressC_d;
            iss_imm_q          <= iss_imm_d;
            iss_muxB_control_q <= iss_muxB_control_d;
        end
    end

    assign iss_alu_valid    = iss_alu_valid_q;
    assign iss_md_start     = iss_md_start_q;
    assign iss_alu_control  = iss_alu_control_q;
    assign iss_addressA     = iss_addressA_q;
    assign iss_addressB     = iss_addressB_q;
    assign iss_addressC     = iss_addressC_q;
    assign iss_imm          = iss_imm_q;
    assign iss_muxB_control = iss_muxB_control_q;
    assign md_ack           = md_ack_int;
    assign wb_en            = (iss_alu_valid_q && iss_addressC_q != 5'd0)
                           || (md_ack_int && md_rd_q != 5'd0);
    assign wb_sel           = md_ack_int;
    assign wb_addr          = md_ack_int ? md_rd_q : iss_addressC_q;
    assign busy             = (state_q != MD_IDLE);

endmodule
